dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
Sequencing controller for the 256-line, 16-word-per-line, direct-mapped read cache. It owns the tag array, valid bits and line data store. It accepts one CPU read at a time, answers hits from the store, and refills the whole line from backing memory on a miss. It sits between the CPU load port and the word-addressed backing memory.

Parameters:
- ADDR_W, 32, address width; word address split as tag[31:12], index[11:4], offset[3:0]
- DATA_W, 32, word width
- INDEX_W, 8, index bits; 256 lines
- OFFSET_W, 4, offset bits; 16 words per line

Ports:
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  read request; accepted when cpu_req && cpu_ready
- cpu_addr  in  32  word address, sampled on accept
- cpu_ready  out  1  controller idle, can accept
- cpu_rvalid  out  1  one-cycle response strobe
- cpu_rdata  out  32  response word, valid with cpu_rvalid
- hit_miss  out  1  1 = hit, 0 = miss; valid with cpu_rvalid
- mem_req  out  1  memory read request for current beat
- mem_addr  out  32  word address of current beat
- mem_rvalid  in  1  memory returns one word; in order, one per request
- mem_rdata  in  32  returned word

Behaviour:
- Reset: all 256 valid bits cleared; FSM = IDLE. Outputs: cpu_ready=1, cpu_rvalid=0, cpu_rdata=0, hit_miss=0, mem_req=0, mem_addr=0. Tag and data arrays are not cleared.
- States: IDLE, LOOKUP, REFILL, RESPOND.
- IDLE: cpu_ready=1. On accept, register cpu_addr and go to LOOKUP. cpu_ready=0 in every other state; cpu_req there is ignored.
- LOOKUP: hit = valid[index] && tag_reg[index]==tag.
  - Hit: register data[index][offset], set hit_miss=1, go to RESPOND.
  - Miss: clear beat counter, go to REFILL.
- Hit latency: accept in cycle N, cpu_rvalid in cycle N+2.
- REFILL:
  - mem_req=1; mem_addr={tag,index,beat}.
  - On mem_rvalid: write mem_rdata to data[index][beat]; capture it as the response word when beat==offset; beat increments.
  - mem_req stays high across beats; memory latency is arbitrary. mem_req is not re-asserted per beat in a pulse fashion; it is level.
  - On mem_rvalid with beat==15: write tag_reg[index]=tag, set valid[index]=1, hit_miss=0, go to RESPOND. mem_req=0 from the next cycle.
- RESPOND: cpu_rvalid=1 for exactly one cycle with cpu_rdata and hit_miss; return to IDLE. cpu_rdata holds its value until the next response.
- Beat counter is 4 bits; it wraps only at refill end and never indexes past 15.
- A refill overwrites the line unconditionally (read-only cache; no dirty state).
- Reset mid-refill: abort immediately. The line's valid bit is left as cleared by reset. Partially written data is don't-care. mem_req=0 next cycle. Late mem_rvalid after reset is ignored in IDLE.
- mem_rvalid outside REFILL is ignored.

Optional Feature:
- Macro: DM_CACHE_PERF_EN.
- Defined:
  - Adds outputs hit_count[31:0] and miss_count[31:0].
  - Each increments in the RESPOND cycle per hit_miss.
  - Both saturate at 0xFFFFFFFF and clear on reset.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package dm_cache_pkg: ADDR_W, DATA_W, INDEX_W, OFFSET_W, TAG_W=20, LINE_WORDS=16, the state enum, and address-field extraction functions (get_tag, get_index, get_offset).
- Sub-module dm_cache_store holds the tag array, valid vector and data array. It does a registered read of tag/valid/word, has a single write port for word and tag, and a synchronous valid clear. dm_cache_ctrl holds only the FSM, beat counter and address register.

Test Plan:
- Cold miss: after reset, read 0x00000013 → mem_addr steps 0x10..0x1F over 16 beats; cpu_rvalid with hit_miss=0 and cpu_rdata=mem[0x13]; then read 0x00000017 → hit_miss=1, data=mem[0x17], cpu_rvalid exactly 2 cycles after accept, mem_req stays 0.
- Conflict eviction: read 0x00000020, read 0x00001020 (same index 2, new tag) → miss with refill; re-read 0x00000020 → miss again.
- Boundary: read 0xFFFFFFFF (tag 0xFFFFF, index 255, offset 15) → miss, critical word captured on the last beat; repeat → hit.
- Memory stall: insert 0–5 random idle cycles between mem_rvalid beats → correct line fill, exactly 16 writes, cpu_req held high during refill not accepted (cpu_ready=0).
- Reset mid-refill: assert reset after beat 7 → mem_req=0 next cycle, cpu_ready=1; re-read same address → full 16-beat refill, hit_miss=0.
- DM_CACHE_PERF_EN: 3 misses + 5 hits → miss_count=3, hit_count=5; reset → both 0.

Source files
------------

// File: rtl/dm_cache_pkg.sv
// dm_cache_pkg: shared parameters, FSM states and address-field helpers for the direct-mapped read cache.
package dm_cache_pkg;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int INDEX_W    = 8;
   localparam int OFFSET_W   = 4;
   localparam int TAG_W      = 20;
   localparam int LINE_WORDS = 16;
   localparam int LINES      = 1 << INDEX_W;
   typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;
   function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: TAG_W];
   endfunction
   function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] a);
      return a[OFFSET_W +: INDEX_W];
   endfunction
   function automatic logic [OFFSET_W-1:0] get_offset(input logic [ADDR_W-1:0] a);
      return a[OFFSET_W-1:0];
   endfunction
endpackage

// File: rtl/dm_cache_store.sv
// dm_cache_store: tag array, valid vector and line data store with registered read,
// a single word/tag write port and a synchronous clear of all valid bits.
module dm_cache_store
   import dm_cache_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic [INDEX_W-1:0]  rd_index_i,
   input  logic [OFFSET_W-1:0] rd_offset_i,
   output logic [TAG_W-1:0]    rd_tag_o,
   output logic                rd_valid_o,
   output logic [DATA_W-1:0]   rd_word_o,
   input  logic                wr_en_i,
   input  logic [INDEX_W-1:0]  wr_index_i,
   input  logic [OFFSET_W-1:0] wr_offset_i,
   input  logic [DATA_W-1:0]   wr_word_i,
   input  logic                tag_we_i,
   input  logic [TAG_W-1:0]    wr_tag_i
);
   logic [TAG_W-1:0]  tag_q  [LINES];
   logic [DATA_W-1:0] data_q [LINES*LINE_WORDS];
   logic [LINES-1:0]  valid_q;
   logic [TAG_W-1:0]  rd_tag_q;
   logic [DATA_W-1:0] rd_word_q;
   logic              rd_valid_q;
   // Tag and data arrays are never reset; only the valid bits qualify their contents.
   always_ff @(posedge clk) begin
      if (wr_en_i) data_q[{wr_index_i, wr_offset_i}] <= wr_word_i;
      if (tag_we_i) tag_q[wr_index_i] <= wr_tag_i;
      rd_tag_q  <= tag_q[rd_index_i];
      rd_word_q <= data_q[{rd_index_i, rd_offset_i}];
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         if (tag_we_i) valid_q[wr_index_i] <= 1'b1;
         rd_valid_q <= valid_q[rd_index_i];
      end
   end
   assign rd_tag_o   = rd_tag_q;
   assign rd_valid_o = rd_valid_q;
   assign rd_word_o  = rd_word_q;
endmodule

// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: sequencing FSM of the 256-line x 16-word direct-mapped read cache.
// Optional hit/miss counters are built when DM_CACHE_PERF_EN is defined.
module dm_cache_ctrl
   import dm_cache_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_ready,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              hit_miss,
`ifdef DM_CACHE_PERF_EN
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count,
`endif
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_rvalid,
   input  logic [DATA_W-1:0] mem_rdata
);
   state_t              state_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [OFFSET_W-1:0] beat_q;
   logic                ready_q;
   logic                rvalid_q;
   logic                hit_q;
   logic [DATA_W-1:0]   rdata_q;
   logic [DATA_W-1:0]   crit_q;
   logic                mem_req_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [TAG_W-1:0]    rd_tag;
   logic                rd_valid;
   logic [DATA_W-1:0]   rd_word;
   logic                hit;
   logic                beat_wr;
   logic                last_beat;
   logic                crit_beat;
   assign hit       = rd_valid && (rd_tag == get_tag(addr_q));
   assign beat_wr   = (state_q == REFILL) && mem_rvalid;
   assign last_beat = beat_q == OFFSET_W'(LINE_WORDS - 1);
   assign crit_beat = beat_q == get_offset(addr_q);
   // Read port follows the live CPU address so the lookup data is ready the cycle after accept.
   dm_cache_store u_store (
      .clk         (clk),
      .reset       (reset),
      .rd_index_i  (get_index(cpu_addr)),
      .rd_offset_i (get_offset(cpu_addr)),
      .rd_tag_o    (rd_tag),
      .rd_valid_o  (rd_valid),
      .rd_word_o   (rd_word),
      .wr_en_i     (beat_wr),
      .wr_index_i  (get_index(addr_q)),
      .wr_offset_i (beat_q),
      .wr_word_i   (mem_rdata),
      .tag_we_i    (beat_wr && last_beat),
      .wr_tag_i    (get_tag(addr_q))
   );
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         beat_q     <= '0;
         ready_q    <= 1'b1;
         rvalid_q   <= 1'b0;
         hit_q      <= 1'b0;
         rdata_q    <= '0;
         crit_q     <= '0;
         mem_req_q  <= 1'b0;
         mem_addr_q <= '0;
      end else begin
         case (state_q)
            IDLE: if (cpu_req && ready_q) begin
               addr_q  <= cpu_addr;
               ready_q <= 1'b0;
               state_q <= LOOKUP;
            end
            LOOKUP: if (hit) begin
               rdata_q  <= rd_word;
               hit_q    <= 1'b1;
               rvalid_q <= 1'b1;
               state_q  <= RESPOND;
            end else begin
               beat_q     <= '0;
               mem_req_q  <= 1'b1;
               mem_addr_q <= {get_tag(addr_q), get_index(addr_q), {OFFSET_W{1'b0}}};
               state_q    <= REFILL;
            end
            REFILL: if (mem_rvalid) begin
               beat_q <= beat_q + 1'b1;
               mem_addr_q[OFFSET_W-1:0] <= beat_q + 1'b1;
               if (crit_beat) crit_q <= mem_rdata;
               // cpu_rdata only changes when the response is issued
               if (last_beat) begin
                  rdata_q   <= crit_beat ? mem_rdata : crit_q;
                  mem_req_q <= 1'b0;
                  hit_q     <= 1'b0;
                  rvalid_q  <= 1'b1;
                  state_q   <= RESPOND;
               end
            end
            RESPOND: begin
               rvalid_q <= 1'b0;
               ready_q  <= 1'b1;
               state_q  <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
`ifdef DM_CACHE_PERF_EN
   logic [31:0] hit_cnt_q;
   logic [31:0] miss_cnt_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else if (state_q == RESPOND) begin
         if (hit_q && !(&hit_cnt_q)) hit_cnt_q <= hit_cnt_q + 1'b1;
         if (!hit_q && !(&miss_cnt_q)) miss_cnt_q <= miss_cnt_q + 1'b1;
      end
   end
   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif
   assign cpu_ready  = ready_q;
   assign cpu_rvalid = rvalid_q;
   assign cpu_rdata  = rdata_q;
   assign hit_miss   = hit_q;
   assign mem_req    = mem_req_q;
   assign mem_addr   = mem_addr_q;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// tb_dm_cache_ctrl: directed and randomized reads against a tag/valid reference model
// and a hashed backing memory; counters checked when DM_CACHE_PERF_EN is defined.
module tb_dm_cache_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic        cpu_ready, cpu_rvalid, hit_miss, mem_req;
   logic [31:0] cpu_rdata, mem_addr;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
`ifdef DM_CACHE_PERF_EN
   logic [31:0] hit_count, miss_count;
`endif
   int          n_chk = 0;
   int          n_fail = 0;
   bit          mvalid [256];
   logic [19:0] mtag [256];
   int          hc = 0;
   int          mc = 0;

   always #5 clk = ~clk;

   dm_cache_ctrl dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_addr   (cpu_addr),
      .cpu_ready  (cpu_ready),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .hit_miss   (hit_miss),
`ifdef DM_CACHE_PERF_EN
      .hit_count  (hit_count),
      .miss_count (miss_count),
`endif
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_rvalid (mem_rvalid),
      .mem_rdata  (mem_rdata)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 256; i++) mvalid[i] = 1'b0;
      hc = 0;
      mc = 0;
   endtask

   task automatic do_read(input logic [31:0] a, input int max_stall, input bit hold, input int abort_at);
      int          cyc, beats, stall, w;
      bit          got, exp_hit;
      logic [7:0]  idx;
      logic [19:0] tg;
      logic [3:0]  bt;
      idx = a[11:4];
      tg = a[31:12];
      exp_hit = mvalid[idx] && (mtag[idx] == tg);
      w = 0;
      while (!cpu_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("ready_before_req", cpu_ready, 1);
      cpu_req = 1'b1;
      cpu_addr = a;
      @(negedge clk);
      cpu_req = hold;
      cyc = 1;
      beats = 0;
      got = 0;
      stall = $urandom_range(max_stall, 0);
      while (!got && cyc < 600) begin
         if (cpu_rvalid) begin
            got = 1;
            cpu_req = 1'b0;
            mem_rvalid = 1'b0;
         end else begin
            chk("busy_not_ready", cpu_ready, 0);
            mem_rvalid = 1'b0;
            if (mem_req) begin
               if (abort_at >= 0 && beats == abort_at) break;
               if (stall > 0) stall--;
               else begin
                  bt = beats[3:0];
                  chk("mem_addr", mem_addr, {a[31:4], bt});
                  mem_rvalid = 1'b1;
                  mem_rdata = mem_word({a[31:4], bt});
                  beats++;
                  stall = $urandom_range(max_stall, 0);
               end
            end
            @(negedge clk);
            cyc++;
         end
      end
      cpu_req = 1'b0;
      if (abort_at >= 0) begin
         reset = 1'b1;
         @(negedge clk);
         reset = 1'b0;
         model_clear();
         chk("abort_beats", beats, abort_at);
         chk("abort_mem_req", mem_req, 0);
         chk("abort_ready", cpu_ready, 1);
         mem_rvalid = 1'b1;
         mem_rdata = 32'hDEADBEEF;
         @(negedge clk);
         mem_rvalid = 1'b0;
         chk("late_rvalid_req", mem_req, 0);
         chk("late_rvalid_ready", cpu_ready, 1);
         chk("late_rvalid_rvalid", cpu_rvalid, 0);
`ifdef DM_CACHE_PERF_EN
         chk("abort_hit_count", hit_count, 0);
         chk("abort_miss_count", miss_count, 0);
`endif
         return;
      end
      chk("got_response", got, 1);
      chk("hit_miss", hit_miss, exp_hit);
      chk("rdata", cpu_rdata, mem_word(a));
      chk("beats", beats, exp_hit ? 0 : 16);
      if (exp_hit) chk("hit_latency", cyc, 2);
      @(negedge clk);
      chk("rvalid_one_cycle", cpu_rvalid, 0);
      chk("rdata_hold", cpu_rdata, mem_word(a));
      chk("ready_after", cpu_ready, 1);
      chk("mem_req_after", mem_req, 0);
      mvalid[idx] = 1'b1;
      mtag[idx] = tg;
      if (exp_hit) hc++;
      else mc++;
`ifdef DM_CACHE_PERF_EN
      chk("hit_count", hit_count, hc);
      chk("miss_count", miss_count, mc);
`endif
   endtask

   initial begin
      logic [31:0] ra;
      model_clear();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_ready", cpu_ready, 1);
      chk("rst_rvalid", cpu_rvalid, 0);
      chk("rst_rdata", cpu_rdata, 0);
      chk("rst_hit_miss", hit_miss, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_addr", mem_addr, 0);
`ifdef DM_CACHE_PERF_EN
      chk("rst_hit_count", hit_count, 0);
      chk("rst_miss_count", miss_count, 0);
`endif
      do_read(32'h0000_0013, 0, 0, -1);
      do_read(32'h0000_0017, 0, 0, -1);
      do_read(32'h0000_0020, 1, 0, -1);
      do_read(32'h0000_1020, 1, 0, -1);
      do_read(32'h0000_0020, 1, 0, -1);
      do_read(32'hFFFF_FFFF, 2, 0, -1);
      do_read(32'hFFFF_FFFF, 2, 0, -1);
      do_read(32'h0000_0A05, 5, 1, -1);
      do_read(32'h0000_0A0C, 5, 1, -1);
      for (int i = 0; i < 40; i++) begin
         ra = {($urandom_range(1, 0) != 0) ? 20'h00ABC : 20'h00123, 8'h40 + 8'($urandom_range(3, 0)),
               4'($urandom_range(15, 0))};
         do_read(ra, 3, ($urandom_range(1, 0) != 0), -1);
      end
      do_read(32'h0000_0345, 2, 0, 8);
      do_read(32'h0000_0345, 2, 0, -1);
      do_read(32'h0000_034A, 0, 0, -1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
